fft8_frame_loader: RTL and testbench



---
 rtl/fft8_frame_loader.sv | 132 +++++++++++++
 tb/tb_fft8_frame_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel ping-pong frame loader feeding the 8-point FFT core.
// Optional FFT8_LOADER_SCALE_EN: pre-scale each stored sample by 1/8 (round-half-up).
module fft8_frame_loader (
    input  logic               clk,
    input  logic               rstn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [23:0] s_real,
    input  logic signed [23:0] s_imag,
    input  logic               s_last,
    input  logic               m_ready,
    output logic               en,
    output logic signed [23:0] x0_real,
    output logic signed [23:0] x1_real,
    output logic signed [23:0] x2_real,
    output logic signed [23:0] x3_real,
    output logic signed [23:0] x4_real,
    output logic signed [23:0] x5_real,
    output logic signed [23:0] x6_real,
    output logic signed [23:0] x7_real,
    output logic signed [23:0] x0_imag,
    output logic signed [23:0] x1_imag,
    output logic signed [23:0] x2_imag,
    output logic signed [23:0] x3_imag,
    output logic signed [23:0] x4_imag,
    output logic signed [23:0] x5_imag,
    output logic signed [23:0] x6_imag,
    output logic signed [23:0] x7_imag,
    output logic               frame_err,
    output logic [7:0]         err_cnt
);
    localparam int N = 8;

    // Handshake: a sample transfers on a rising edge where s_valid && s_ready;
    // a frame transfers on an edge where a full bank is pending and m_ready is high,
    // and is announced by en in the following cycle.

    logic [23:0] mem_r [2][N];
    logic [23:0] mem_i [2][N];
    logic [23:0] xr [N];
    logic [23:0] xi [N];
    logic [2:0]  idx;
    logic        wr_bank;
    logic        rd_bank;
    logic [1:0]  full;
    logic        accept;
    logic        fill_done;
    logic        short_end;
    logic        drain;

    function automatic logic [23:0] prep(input logic [23:0] x);
`ifdef FFT8_LOADER_SCALE_EN
        logic signed [24:0] t;
        logic signed [24:0] s;
        t = $signed({x[23], x}) + 25'sd4;
        s = t >>> 3;
        prep = s[23:0];
`else
        prep = x;
`endif
    endfunction

    // Only registers feed s_ready, so upstream never sees a combinational loop.
    assign s_ready   = ~(full[0] & full[1]);
    assign accept    = s_valid & s_ready;
    assign fill_done = accept & (idx == 3'd7);
    assign short_end = accept & s_last & (idx != 3'd7);
    assign drain     = full[rd_bank] & m_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_r[wr_bank][idx] <= prep(s_real);
            mem_i[wr_bank][idx] <= prep(s_imag);
        end
    end

    // Drain and fill always address different banks: drain needs a full bank,
    // accept needs the write bank to be empty.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx       <= 3'd0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            en        <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= 8'd0;
            for (int k = 0; k < N; k++) begin
                xr[k] <= 24'd0;
                xi[k] <= 24'd0;
            end
        end else begin
            en        <= drain;
            frame_err <= short_end;
            if (drain) begin
                for (int k = 0; k < N; k++) begin
                    xr[k] <= mem_r[rd_bank][k];
                    xi[k] <= mem_i[rd_bank][k];
                end
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (fill_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
                idx           <= 3'd0;
            end else if (short_end) begin
                idx <= 3'd0;
                if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            end else if (accept) begin
                idx <= idx + 3'd1;
            end
        end
    end

    assign x0_real = xr[0];
    assign x1_real = xr[1];
    assign x2_real = xr[2];
    assign x3_real = xr[3];
    assign x4_real = xr[4];
    assign x5_real = xr[5];
    assign x6_real = xr[6];
    assign x7_real = xr[7];
    assign x0_imag = xi[0];
    assign x1_imag = xi[1];
    assign x2_imag = xi[2];
    assign x3_imag = xi[3];
    assign x4_imag = xi[4];
    assign x5_imag = xi[5];
    assign x6_imag = xi[6];
    assign x7_imag = xi[7];
endmodule

// File: tb/tb_fft8_frame_loader.sv
// Bench for fft8_frame_loader: sample driver, frame scoreboard keyed on en, directed scenarios.
module tb_fft8_frame_loader;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic m_ready = 1'b0;
    logic signed [23:0] s_real = '0;
    logic signed [23:0] s_imag = '0;
    logic s_ready, en, frame_err;
    logic [7:0] err_cnt;
    logic signed [23:0] xr [8];
    logic signed [23:0] xi [8];

    int tests = 0;
    int fails = 0;
    logic [383:0] exp_q[$];
    logic signed [23:0] cur_r [8];
    logic signed [23:0] cur_i [8];
    int cur_idx = 0;
    int exp_err = 0;
    int exp_err_events = 0;
    int obs_err_pulses = 0;
    bit chk_ready_hi = 1'b0;
    logic signed [23:0] sc_in [8];
    logic signed [23:0] sc_out [8];

    fft8_frame_loader dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .s_last(s_last), .m_ready(m_ready), .en(en),
        .x0_real(xr[0]), .x1_real(xr[1]), .x2_real(xr[2]), .x3_real(xr[3]),
        .x4_real(xr[4]), .x5_real(xr[5]), .x6_real(xr[6]), .x7_real(xr[7]),
        .x0_imag(xi[0]), .x1_imag(xi[1]), .x2_imag(xi[2]), .x3_imag(xi[3]),
        .x4_imag(xi[4]), .x5_imag(xi[5]), .x6_imag(xi[6]), .x7_imag(xi[7]),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [23:0] model(input logic signed [23:0] x);
`ifdef FFT8_LOADER_SCALE_EN
        logic signed [24:0] t;
        t = (x + 25'sd4) >>> 3;
        return t[23:0];
`else
        return x;
`endif
    endfunction

    function automatic logic [383:0] pack_cur();
        logic [383:0] v;
        for (int k = 0; k < 8; k++) v[k*48 +: 48] = {cur_i[k], cur_r[k]};
        return v;
    endfunction

    // driver: holds the sample until accepted, then updates the expected model
    task automatic send(input logic signed [23:0] r, input logic signed [23:0] i, input logic last);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        s_real = r;
        s_imag = i;
        s_last = last;
        s_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        s_valid = 1'b0;
        s_last = 1'b0;
        if (!acc) begin
            check("send_timeout", 0, 1);
        end else begin
            cur_r[cur_idx] = model(r);
            cur_i[cur_idx] = model(i);
            if (last && cur_idx < 7) begin
                cur_idx = 0;
                exp_err_events++;
                if (exp_err < 255) exp_err++;
            end else if (cur_idx == 7) begin
                exp_q.push_back(pack_cur());
                cur_idx = 0;
            end else begin
                cur_idx++;
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rstn) begin
            if (en) begin
                if (exp_q.size() == 0) begin
                    check("en_unexpected", 1, 0);
                end else begin
                    logic [383:0] e;
                    logic [383:0] a;
                    e = exp_q.pop_front();
                    for (int k = 0; k < 8; k++) a[k*48 +: 48] = {xi[k], xr[k]};
                    tests++;
                    if (a !== e) begin
                        fails++;
                        $display("FAIL frame: got %h, expected %h", a, e);
                    end
                end
            end
            if (frame_err) begin
                obs_err_pulses++;
                check("err_cnt_on_pulse", {24'd0, err_cnt}, exp_err);
            end
            if (chk_ready_hi) check("s_ready_hi", {31'd0, s_ready}, 1);
        end
    end

    initial begin
        sc_in  = '{24'sd12, -24'sd12, 24'sd8388607, -24'sd8388608, 24'sd3, -24'sd4, 24'sd5, -24'sd5};
`ifdef FFT8_LOADER_SCALE_EN
        sc_out = '{24'sd2, -24'sd1, 24'sd1048576, -24'sd1048576, 24'sd0, 24'sd0, 24'sd1, -24'sd1};
`else
        sc_out = sc_in;
`endif
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_en", {31'd0, en}, 0);
        check("rst_x0r", xr[0], 0);
        check("rst_x7i", xi[7], 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_err_cnt", {24'd0, err_cnt}, 0);
        check("rst_s_ready", {31'd0, s_ready}, 1);
        @(posedge clk);
        #1;

        // single frame, m_ready high
        m_ready = 1'b1;
        chk_ready_hi = 1'b1;
        for (int k = 1; k <= 8; k++) send(24'(k), 24'(-k), k == 8);
        @(negedge clk);
        check("en_early", {31'd0, en}, 0);
        @(negedge clk);
        check("en_latency", {31'd0, en}, 1);
        check("x0_real", xr[0], 1);
        check("x7_real", xr[7], 8);
        check("x7_imag", xi[7], -8);
        @(negedge clk);
        check("en_single", {31'd0, en}, 0);
        chk_ready_hi = 1'b0;
        @(posedge clk);
        #1;

        // two buffered frames, then backpressure
        m_ready = 1'b0;
        for (int k = 1; k <= 16; k++) send(24'(100 + k), 24'(-100 - k), 1'b0);
        @(negedge clk);
        check("s_ready_full", {31'd0, s_ready}, 0);
        @(posedge clk);
        #1;
        fork
            for (int k = 17; k <= 24; k++) send(24'(100 + k), 24'(-100 - k), 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 m_ready = 1'b1;
                @(posedge clk);
                #1;
                @(negedge clk);
                check("en_b2b_first", {31'd0, en}, 1);
                check("s_ready_back", {31'd0, s_ready}, 1);
                @(negedge clk);
                check("en_b2b_second", {31'd0, en}, 1);
            end
        join
        repeat (4) @(negedge clk);
        check("q_drained_2", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // short frame, recovery, saturation
        for (int k = 1; k <= 5; k++) send(24'(k), 24'(k), k == 5);
        @(negedge clk);
        check("frame_err_pulse", {31'd0, frame_err}, 1);
        check("err_cnt_1", {24'd0, err_cnt}, 1);
        @(negedge clk);
        check("frame_err_single", {31'd0, frame_err}, 0);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 8; k++) send(24'(200 + k), 24'(-200 - k), 1'b0);
        repeat (3) @(negedge clk);
        check("q_drained_3", exp_q.size(), 0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 300; n++) send(24'(n), 24'(-n), 1'b1);
        repeat (2) @(negedge clk);
        check("err_sat", {24'd0, err_cnt}, 255);
        check("err_pulses", obs_err_pulses, exp_err_events);
        @(posedge clk);
        #1;

        // reset with a full bank pending and a partial frame
        m_ready = 1'b0;
        for (int k = 1; k <= 13; k++) send(24'(400 + k), 24'(-400 - k), 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        exp_q.delete();
        cur_idx = 0;
        exp_err = 0;
        @(negedge clk);
        check("rst2_en", {31'd0, en}, 0);
        check("rst2_x0r", xr[0], 0);
        check("rst2_x3i", xi[3], 0);
        check("rst2_frame_err", {31'd0, frame_err}, 0);
        check("rst2_err_cnt", {24'd0, err_cnt}, 0);
        check("rst2_s_ready", {31'd0, s_ready}, 1);
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst2_no_en", {31'd0, en}, 0);
        end
        @(posedge clk);
        #1;
        for (int k = 1; k <= 8; k++) send(24'(500 + k), 24'(-500 - k), 1'b0);
        repeat (3) @(negedge clk);
        check("q_drained_4", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // extreme values (scaled when the option is built in)
        for (int k = 0; k < 8; k++) send(sc_in[k], 24'(k), 1'b0);
        repeat (2) @(negedge clk);
        check("scale_en", {31'd0, en}, 1);
        for (int k = 0; k < 8; k++) check($sformatf("scale_x%0d_real", k), xr[k], sc_out[k]);
        repeat (2) @(negedge clk);
        check("q_drained_final", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
